// File: rtl/wb_result_select_trace.sv
// Writeback result select, registered regfile write port and ready/valid debug trace FIFO.
// Optional macro WB_TRACE_SKIP_NOWRITE_EN: do not trace accepted instructions with no byte enables.
module wb_result_select_trace #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned NSRC        = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [PC_W-1:0]        in_pc_plus8,
  input  logic                   in_pc_to_reg,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [NSRC*DATA_W-1:0] in_src_data,
  input  logic [3:0]             in_reg_wen,
  input  logic [REG_AW-1:0]      in_reg_wnum,
  output logic [3:0]             rf_we,
  output logic [REG_AW-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [PC_W-1:0]        debug_wb_pc,
  output logic [3:0]             debug_wb_rf_wen,
  output logic [REG_AW-1:0]      debug_wb_rf_wnum,
  output logic [DATA_W-1:0]      debug_wb_rf_wdata
);

  localparam int unsigned PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TRACE_DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [3:0]        wen;
    logic [REG_AW-1:0] wnum;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  trace_entry_t      mem [TRACE_DEPTH];
  trace_entry_t      head;
  logic [DATA_W-1:0] link_data;
  logic [DATA_W-1:0] sel_data;
  logic [3:0]        wen_eff;
  logic              acc;
  logic              push;
  logic              pop;

  // Link value resized to the register width (zero-extend or truncate)
  generate
    if (PC_W >= DATA_W) begin : g_link_trunc
      assign link_data = in_pc_plus8[DATA_W-1:0];
    end else begin : g_link_zext
      assign link_data = {{(DATA_W-PC_W){1'b0}}, in_pc_plus8};
    end
  endgenerate

  // Result mux: PC+8 wins, out-of-range selects give zero
  always_comb begin
    sel_data = '0;
    if (in_pc_to_reg) begin
      sel_data = link_data;
    end else begin
      for (int k = 0; k < int'(NSRC); k++) begin
        if (in_sel == SEL_W'(k)) sel_data = in_src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign wen_eff     = (in_reg_wnum == '0) ? 4'b0000 : in_reg_wen;
  assign in_ready    = (count != DEPTH_C);
  assign trace_valid = (count != '0);
  assign acc         = in_valid & in_ready & ~flush;
  assign pop         = trace_valid & trace_ready;

`ifdef WB_TRACE_SKIP_NOWRITE_EN
  assign push = acc & (wen_eff != 4'b0000);
`else
  assign push = acc;
`endif

  // Regfile write port: enables pulse on accept, address/data hold otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we    <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (acc) begin
      rf_we    <= wen_eff;
      rf_waddr <= in_reg_wnum;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= '0;
    end
  end

  // Trace FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, wen: wen_eff, wnum: in_reg_wnum, data: sel_data};
    end
  end

  assign head              = mem[rd_ptr];
  assign debug_wb_pc       = trace_valid ? head.pc   : '0;
  assign debug_wb_rf_wen   = trace_valid ? head.wen  : '0;
  assign debug_wb_rf_wnum  = trace_valid ? head.wnum : '0;
  assign debug_wb_rf_wdata = trace_valid ? head.data : '0;

endmodule

// File: tb/tb_wb_result_select_trace.sv
// Directed plus randomized checks of wb_result_select_trace against a queue-based reference model.
module tb_wb_result_select_trace;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, flush, in_pc_to_reg, trace_ready;
  logic [31:0] in_pc, in_pc_plus8;
  logic [2:0]  in_sel;
  logic [31:0] src [4];
  logic [127:0] in_src_data;
  logic [3:0]  in_reg_wen;
  logic [4:0]  in_reg_wnum;
  logic        in_ready, trace_valid;
  logic [3:0]  rf_we, debug_wb_rf_wen;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  ent_t        mq[$];
  logic [3:0]  m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  assign in_src_data = {src[3], src[2], src[1], src[0]};

  always #5 clock = ~clock;

  wb_result_select_trace #(
    .DATA_W(32), .PC_W(32), .NSRC(4), .SEL_W(3), .REG_AW(5), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .in_pc(in_pc), .in_pc_plus8(in_pc_plus8), .in_pc_to_reg(in_pc_to_reg),
    .in_sel(in_sel), .in_src_data(in_src_data),
    .in_reg_wen(in_reg_wen), .in_reg_wnum(in_reg_wnum),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic compare_all();
    check("rf_we", 64'(rf_we), 64'(m_we));
    check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    check("trace_valid", 64'(trace_valid), 64'(mq.size() != 0));
    check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    if (mq.size() != 0) begin
      check("dbg_pc", 64'(debug_wb_pc), 64'(mq[0].pc));
      check("dbg_wen", 64'(debug_wb_rf_wen), 64'(mq[0].wen));
      check("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(mq[0].wnum));
      check("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(mq[0].data));
    end else begin
      check("dbg_empty", 64'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum}) | 64'(debug_wb_rf_wdata), 64'd0);
    end
  endtask

  // One clock: model consumes the current inputs, DUT takes the edge, then compare
  task automatic cycle();
    logic [3:0]  we;
    logic [31:0] d;
    bit          acc;
    ent_t        e;
    we  = (in_reg_wnum == 5'd0) ? 4'd0 : in_reg_wen;
    if (in_pc_to_reg)    d = in_pc_plus8;
    else if (in_sel < 4) d = src[in_sel[1:0]];
    else                 d = 32'd0;
    acc = in_valid && (mq.size() < DEPTH) && !flush;
    if (mq.size() != 0 && trace_ready) void'(mq.pop_front());
    if (acc) begin
      m_we = we; m_waddr = in_reg_wnum; m_wdata = d;
      e.pc = in_pc; e.wen = we; e.wnum = in_reg_wnum; e.data = d;
`ifdef WB_TRACE_SKIP_NOWRITE_EN
      if (we != 4'd0) mq.push_back(e);
`else
      mq.push_back(e);
`endif
    end else begin
      m_we = 4'd0;
    end
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] sel,
                       input logic [4:0] wnum, input logic [3:0] wen);
    in_valid = v; in_pc = pc; in_pc_plus8 = pc + 32'd8; in_sel = sel;
    in_reg_wnum = wnum; in_reg_wen = wen; in_pc_to_reg = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; trace_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    src[0] = 32'h11111111; src[1] = 32'h22222222; src[2] = 32'h33333333; src[3] = 32'h44444444;
    drive(1'b0, 32'h0, 3'd0, 5'd0, 4'd0);
    trace_ready = 1'b0;
    m_we = '0; m_waddr = '0; m_wdata = '0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clock);
    compare_all();
    reset = 1'b1;
    @(negedge clock);
    compare_all();

    // Source select
    trace_ready = 1'b1;
    drive(1'b1, 32'hBFC00000, 3'd2, 5'd8, 4'hF);
    cycle();
    check("sel_wdata", 64'(rf_wdata), 64'h33333333);
    check("sel_we", 64'(rf_we), 64'hF);
    check("sel_waddr", 64'(rf_waddr), 64'd8);
    check("sel_head", 64'(debug_wb_rf_wdata), 64'h33333333);
    drain();

    // Out-of-range select reads zero
    drive(1'b1, 32'hBFC00010, 3'd6, 5'd3, 4'h3);
    cycle();
    check("oor_wdata", 64'(rf_wdata), 64'd0);
    drain();

    // Link write
    drive(1'b1, 32'hBFC00100, 3'd0, 5'd31, 4'hF);
    in_pc_to_reg = 1'b1;
    cycle();
    check("link_wdata", 64'(rf_wdata), 64'hBFC00108);
    check("link_pc", 64'(debug_wb_pc), 64'hBFC00100);
    check("link_wnum", 64'(debug_wb_rf_wnum), 64'd31);
    drain();

    // Register zero
    drive(1'b1, 32'hBFC00200, 3'd1, 5'd0, 4'hF);
    cycle();
    check("zr_we", 64'(rf_we), 64'd0);
`ifdef WB_TRACE_SKIP_NOWRITE_EN
    check("zr_notrace", 64'(trace_valid), 64'd0);
`else
    check("zr_trace", 64'(trace_valid), 64'd1);
    check("zr_trace_wen", 64'(debug_wb_rf_wen), 64'd0);
`endif
    drain();

    // Back-pressure: four fit, fifth waits until one cycle after the first pop
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), 3'(i % 4), 5'(i + 1), 4'hF);
      cycle();
      if (i == 3) check("bp_full", 64'(in_ready), 64'd0);
    end
    check("bp_fifth_blocked", 64'(debug_wb_pc), 64'h1000);
    trace_ready = 1'b1;
    cycle();
    check("bp_slot_free", 64'(in_ready), 64'd1);
    cycle();
    drain();

    // Flush drops the instruction
    trace_ready = 1'b0;
    drive(1'b1, 32'h2000, 3'd1, 5'd4, 4'hF);
    cycle();
    drive(1'b1, 32'h2004, 3'd3, 5'd5, 4'hF);
    flush = 1'b1;
    cycle();
    check("flush_we", 64'(rf_we), 64'd0);
    check("flush_waddr_hold", 64'(rf_waddr), 64'd4);
    // Concurrent push and pop at count 2
    drive(1'b1, 32'h2008, 3'd0, 5'd6, 4'hF);
    cycle();
    trace_ready = 1'b1;
    drive(1'b1, 32'h200C, 3'd2, 5'd7, 4'h1);
    cycle();
    check("pp_head", 64'(debug_wb_pc), 64'h2008);
    drain();

    // Asynchronous reset with three entries buffered
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(i * 4), 3'd1, 5'(i + 9), 4'hF);
      cycle();
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("ar_trace_valid", 64'(trace_valid), 64'd0);
    check("ar_rf_we", 64'(rf_we), 64'd0);
    check("ar_rf_wdata", 64'(rf_wdata), 64'd0);
    check("ar_dbg_pc", 64'(debug_wb_pc), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    mq.delete();
    m_we = '0; m_waddr = '0; m_wdata = '0;
    @(negedge clock);
    reset = 1'b1;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 9) == 0);
      trace_ready  = ($urandom_range(0, 1) == 1);
      in_pc_to_reg = ($urandom_range(0, 4) == 0);
      in_pc        = $urandom;
      in_pc_plus8  = in_pc + 32'd8;
      in_sel       = 3'($urandom_range(0, 7));
      in_reg_wnum  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_reg_wen   = 4'($urandom);
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_result_select_trace.md
Name: wb_result_select_trace

Overview:
- Parametrised writeback-stage result unit for the MIPS core.
- Selects the register-file write data from NSRC execution sources, with a PC+8 override for link instructions.
- Registers the regfile write port.
- Buffers the debug writeback trace (pc/wen/wnum/wdata) in a small FIFO with a ready/valid handshake, so trace back-pressure stalls writeback instead of losing entries.

Parameters:
- DATA_W, 32, width of result data and register file word.
- PC_W, 32, width of PC fields.
- NSRC, 4, number of selectable result sources (ALU, MEM, HI, LO in the default configuration).
- SEL_W, 2, width of the source select; must satisfy 2^SEL_W >= NSRC.
- REG_AW, 5, register number width.
- TRACE_DEPTH, 4, trace FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- in_valid  in  1  a writeback instruction is presented.
- in_ready  out  1  unit can accept; equals !trace_full.
- flush  in  1  drop the presented instruction this cycle.
- in_pc  in  PC_W  PC of the instruction.
- in_pc_plus8  in  PC_W  link value.
- in_pc_to_reg  in  1  select in_pc_plus8 as write data.
- in_sel  in  SEL_W  source index.
- in_src_data  in  NSRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W].
- in_reg_wen  in  4  byte write enables.
- in_reg_wnum  in  REG_AW  destination register.
- rf_we  out  4  registered regfile byte enables.
- rf_waddr  out  REG_AW  registered destination.
- rf_wdata  out  DATA_W  registered write data.
- trace_valid  out  1  FIFO head is valid.
- trace_ready  in  1  trace consumer accepts the head.
- debug_wb_pc  out  PC_W  head PC.
- debug_wb_rf_wen  out  4  head byte enables.
- debug_wb_rf_wnum  out  REG_AW  head register.
- debug_wb_rf_wdata  out  DATA_W  head data.

Behaviour:
- Accept condition: acc = in_valid & in_ready & !flush.
- Data select, combinational:
  - If in_pc_to_reg = 1: data = in_pc_plus8, zero-extended or truncated to DATA_W. PC+8 has priority over in_sel.
  - Else if in_sel < NSRC: data = source[in_sel].
  - Else: data = 0.
- Effective enable: wen_eff = (in_reg_wnum == 0) ? 4'b0000 : in_reg_wen.
- Regfile port:
  - Registered, latency 1.
  - On acc at edge T: rf_we = wen_eff, rf_waddr = in_reg_wnum, rf_wdata = data, all valid in cycle T+1.
  - Cycle without acc: rf_we = 0; rf_waddr and rf_wdata hold their previous values.
- Trace FIFO:
  - Circular buffer with rd/wr pointers of log2(TRACE_DEPTH) bits and a count of log2(TRACE_DEPTH)+1 bits.
  - Push on acc; entry = {in_pc, wen_eff, in_reg_wnum, data}.
  - Pop when trace_valid & trace_ready.
  - trace_valid = (count != 0).
  - Debug outputs show the head entry and are 0 when the FIFO is empty.
- Empty FIFO: a push at edge T makes the entry visible at T+1. No combinational pass-through.
- Full FIFO: in_ready = 0, even if a pop occurs in the same cycle; the freed slot becomes usable the next cycle.
- Simultaneous push and pop with 0 < count < TRACE_DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo TRACE_DEPTH.
- flush: suppresses acc for that cycle only. It never clears the FIFO or the regfile port registers. An in_valid with flush = 1 is neither written nor traced.
- Reset, async assert:
  - count, pointers = 0.
  - rf_we, rf_waddr, rf_wdata = 0.
  - trace_valid = 0; all debug outputs = 0.
  - in_ready = 1 one cycle after deassertion, and combinationally during reset (count = 0).
- Reset mid-operation discards all buffered trace entries.

Optional Feature:
- Macro: WB_TRACE_SKIP_NOWRITE_EN.
- Defined: an accepted instruction with wen_eff == 0 updates the regfile port (rf_we = 0) but is not pushed to the trace FIFO. The trace then matches the golden reference trace, which logs only register writes.
- Undefined: every accepted instruction is pushed, including entries with wen = 0.

Test Plan:
- Select: sources {0x11111111, 0x22222222, 0x33333333, 0x44444444}, in_sel = 2, in_pc_to_reg = 0, wnum = 8, wen = 0xF -> next cycle rf_wdata = 0x33333333, rf_we = 0xF, rf_waddr = 8; trace head = 0x33333333.
- Link: in_pc = 0xBFC00100, in_pc_plus8 = 0xBFC00108, in_pc_to_reg = 1, in_sel = 0, wnum = 31 -> rf_wdata = 0xBFC00108, debug_wb_pc = 0xBFC00100, debug_wb_rf_wnum = 31.
- Zero register: wnum = 0, wen = 0xF -> rf_we = 0. Trace entry has wen = 0 when the macro is undefined; no entry is pushed when it is defined.
- Back-pressure: trace_ready = 0, five back-to-back valid instructions (DEPTH = 4) -> four accepted, in_ready = 0 on the fifth. Raise trace_ready -> entries drain in order, and the fifth is accepted one cycle after the first pop.
- Flush: in_valid = 1, flush = 1 -> rf_we = 0 next cycle, count unchanged. Concurrent push and pop at count = 2 -> count stays 2.
- Reset: assert reset low asynchronously with three entries buffered -> trace_valid, rf_we and debug outputs go to 0 immediately; after release, in_ready = 1 and the FIFO is empty.
